// File: rtl/uart_tx8_if.sv
// Parallel-side signals of the 8N1 UART transmitter: request, byte, line and status.
interface uart_tx8_if;
  logic       txEn;
  logic       txStart;
  logic [7:0] txIn;
  logic       txOut;
  logic       txBusy;
  logic       txDone;

  modport master (output txEn, txStart, txIn, input txOut, txBusy, txDone);
  modport slave  (input txEn, txStart, txIn, output txOut, txBusy, txDone);
endinterface

// File: rtl/uart_tx8.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit,
// each bit held for CLOCK_RATE / BAUD_RATE clock cycles.
module uart_tx8 #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input logic       clk,
  input logic       reset,
  uart_tx8_if.slave tx
);
  localparam int DIV = CLOCK_RATE / BAUD_RATE;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_tx8: CLOCK_RATE / BAUD_RATE must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] baud_cnt, baud_cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    data, data_nx;
  logic          line, line_nx;
  logic          done, done_nx;
  logic          bit_end;

  assign bit_end = (baud_cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset is in the sensitivity list so it acts without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data     <= '0;
      line     <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_cnt_nx;
      bit_idx  <= bit_idx_nx;
      data     <= data_nx;
      line     <= line_nx;
      done     <= done_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    baud_cnt_nx = baud_cnt + 1'b1;
    bit_idx_nx  = bit_idx;
    data_nx     = data;
    line_nx     = line;
    done_nx     = 1'b0;

    unique case (state)
      IDLE: begin
        baud_cnt_nx = '0;
        bit_idx_nx  = '0;
        line_nx     = 1'b1;
        if (tx.txEn && tx.txStart) begin
          state_nx = START;
          data_nx  = tx.txIn;
          line_nx  = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx    = DATA;
          baud_cnt_nx = '0;
          bit_idx_nx  = '0;
          line_nx     = data[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_nx = '0;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
            line_nx  = 1'b1;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            line_nx    = data[bit_idx_nx];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx    = IDLE;
          baud_cnt_nx = '0;
          line_nx     = 1'b1;
          done_nx     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The line comes straight from a flop, so it never glitches.
  assign tx.txOut  = line;
  assign tx.txBusy = (state != IDLE);
  assign tx.txDone = done;
endmodule
